// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: runs one req/ack bus transaction per load or store,
// steers byte/halfword lanes, extends load data, and flags misalignment and bus timeouts.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        bus_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] read_data_q, read_data_d;
    logic        bus_timeout_q, bus_timeout_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        access;
    logic        addr_bad;
    logic        start;
    logic        timeout_hit;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{~zext & b[7]}}, b};
            2'b01:   r = {{16{~zext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        access      = mem_read | mem_write;
        addr_bad    = ((mem_size == 2'b01) & addr[0]) | (mem_size[1] & (addr[1:0] != 2'b00));
        start       = (state_q == IDLE) & access & ~addr_bad;
        timeout_hit = (cnt_q == CNT_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            size_q        <= '0;
            unsigned_q    <= 1'b0;
            lane_q        <= '0;
            read_data_q   <= '0;
            bus_timeout_q <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wstrb_q   <= '0;
            bus_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            lane_q        <= lane_d;
            read_data_q   <= read_data_d;
            bus_timeout_q <= bus_timeout_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wstrb_q   <= bus_wstrb_d;
            bus_wdata_q   <= bus_wdata_d;
        end
    end

    // DONE always returns to IDLE so the completed access is never re-issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (bus_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lane_strb  = 4'hF;
        lane_wdata = write_data;
        case (mem_size)
            2'b00: begin
                lane_strb  = 4'b0001 << addr[1:0];
                lane_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                lane_strb  = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        lane_d        = lane_q;
        read_data_d   = read_data_q;
        bus_timeout_d = 1'b0;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wstrb_d   = bus_wstrb_q;
        bus_wdata_d   = bus_wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d       = '0;
                    size_d      = mem_size;
                    unsigned_d  = mem_unsigned;
                    lane_d      = addr[1:0];
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_wstrb_d = mem_write ? lane_strb : 4'b0000;
                    bus_wdata_d = mem_write ? lane_wdata : 32'h0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 16'd1;
                // An ack arriving on the last allowed cycle still completes normally.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) read_data_d = extend_load(bus_rdata, size_q, lane_q, unsigned_q);
                end else if (timeout_hit) begin
                    bus_req_d     = 1'b0;
                    bus_timeout_d = 1'b1;
                    if (!bus_we_q) read_data_d = 32'h0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        stall      = ~reset & (start | (state_q == BUSY));
        misaligned = ~reset & (state_q == IDLE) & access & addr_bad;
    end

    assign read_data   = read_data_q;
    assign bus_timeout = bus_timeout_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wstrb   = bus_wstrb_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage access controller. It sits between the EX/MEM pipeline outputs and the external data-memory bus, and produces the load data and stall that feed the MEM/WB register. It runs a request/acknowledge bus transaction per load or store, and handles byte and halfword lanes with sign or zero extension. It flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, number of BUSY cycles without bus_ack before the access is aborted (1..65535).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
mem_read  input  1  load request from EX/MEM
mem_write  input  1  store request from EX/MEM
mem_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned  input  1  1 = zero-extend load, 0 = sign-extend
addr  input  32  byte address (ALU result)
write_data  input  32  store data, right-justified
stall  output  1  hold IF/ID/EX/MEM stages this cycle
read_data  output  32  extended load result to MEM/WB
misaligned  output  1  misaligned access flag (combinational)
bus_timeout  output  1  one-cycle pulse on timeout abort
bus_req  output  1  bus request
bus_we  output  1  1 = write transaction
bus_addr  output  32  word address: addr[31:2], 2'b00
bus_wstrb  output  4  byte enables, little-endian lanes
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  transaction complete; sampled only in BUSY
bus_rdata  input  32  read word; valid with bus_ack

Behaviour:
- Reset values: state IDLE, stall 0, read_data 0, bus_timeout 0, bus_req 0, bus_we 0, bus_addr 0, bus_wstrb 0, bus_wdata 0, timeout counter 0. Asserting reset in BUSY drops bus_req immediately, with no completion.
- access = mem_read | mem_write. If both are set, the access is a write.
- misaligned = access & ((half & addr[0]) | (word & addr[1:0]!=0)). It is high only in IDLE.
- A misaligned access issues no bus transaction and stall stays 0. read_data is unchanged. The pipeline advances.
- States:
  - IDLE: on access & !misaligned, go to BUSY at the next edge. At that edge, latch bus_addr, bus_we, bus_wstrb, bus_wdata, size, unsigned and addr[1:0], and set bus_req=1 and counter=0.
  - BUSY: bus_req held high, outputs stable. Counter increments each cycle.
    - bus_ack=1: go to DONE, bus_req←0. On a read, read_data←extended bus_rdata.
    - Counter = TIMEOUT_CYCLES-1 with no ack: go to DONE, bus_req←0, bus_timeout←1. On a read, read_data←0.
    - Ack and the timeout limit in the same cycle: ack wins, no timeout.
  - DONE: lasts one cycle with stall=0 so the pipeline advances and MEM/WB captures read_data. bus_timeout clears. Go to IDLE at the next edge, with no re-issue of the same access.
- stall (combinational) = (IDLE & access & !misaligned) | BUSY.
- Minimum load/store latency: issue edge, then ack seen in the first BUSY cycle, then DONE. The pipeline stalls 2 cycles.
- Write lanes:
  - Byte: wstrb = 1<<addr[1:0], wdata = {4{wd[7:0]}}.
  - Half: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}.
  - Word: wstrb = 1111, wdata = wd.
  - For reads, bus_wstrb = 0000.
- Read lanes: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]. Extend to 32 bits per mem_unsigned. Word reads pass through unchanged.
- read_data changes only on a read completion or a read timeout. Stores and idle cycles hold the value.
- bus_ack outside BUSY is ignored.

Test Plan:
- Word load at addr 0x100, ack in the first BUSY cycle, rdata 0xDEADBEEF → bus_addr 0x100, bus_we 0, stall high 2 cycles, read_data 0xDEADBEEF in DONE.
- Byte load at addr 0x103, rdata 0x80112233: signed → read_data 0xFFFFFF80; unsigned → 0x00000080.
- Half store at addr 0x206, write_data 0x0000ABCD, ack after 3 BUSY cycles → bus_wstrb 1100, bus_wdata 0xABCDABCD, bus_addr 0x204, stall high 4 cycles, read_data unchanged.
- Word load at addr 0x102 → misaligned=1 that cycle, bus_req never asserted, stall 0.
- TIMEOUT_CYCLES=4, load with no ack → bus_req high exactly 4 cycles, bus_timeout pulses 1 cycle, read_data 0, stall drops in DONE.
- Reset asserted mid-BUSY → bus_req, stall and all outputs 0 immediately. After release, a new load completes normally; ack in the same cycle as the timeout limit produces no timeout.
